pixel_sequencer: RTL

PIXEL_SEQUENCER -- requirements
Module: pixel_sequencer

---
 rtl/pixel_pkg.sv | 28 ++
 rtl/phase_timer.sv | 41 ++++
 rtl/pixel_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pixel_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pixel_pkg : state encoding and default geometry for the sequencer |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
package pixel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_SETTLE  = 3'd4,
    ST_CAPTURE = 3'd5,
    ST_OUTPUT  = 3'd6
  } state_e;

  localparam int DEF_PIXEL_COUNT   = 4;
  localparam int DEF_COUNTER_WIDTH = 8;
  localparam int DEF_ERASE_CYCLES  = 5;

  // Duration counter must hold a full 16-bit exposure and the whole ramp window.
  function automatic int timer_width(input int counter_width);
    return (counter_width + 1 > 16) ? counter_width + 1 : 16;
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | phase_timer : loadable down-counter, done while count is zero     |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module phase_timer
  import pixel_pkg::*;
#(
  parameter int WIDTH = timer_width(DEF_COUNTER_WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Saturates at zero so a long idle phase can never wrap into a false count.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/pixel_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pixel_sequencer : erase/expose/convert/readout control of an array|
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module pixel_sequencer
  import pixel_pkg::*;
#(
  parameter int PIXEL_COUNT   = DEF_PIXEL_COUNT,
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
  parameter int ERASE_CYCLES  = DEF_ERASE_CYCLES
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           cds_en,
  input  logic [15:0]                    expose_time,
  output logic                           arr_reset,
  output logic                           erase,
  output logic                           expose,
  output logic                           convert,
  output logic                           corr,
  output logic                           cds,
  output logic                           read,
  output logic [$clog2(PIXEL_COUNT)-1:0] pixel_select,
  input  logic [COUNTER_WIDTH-1:0]       pixel_out,
  output logic [COUNTER_WIDTH-1:0]       px_data,
  output logic [$clog2(PIXEL_COUNT)-1:0] px_index,
  output logic                           px_valid,
  input  logic                           px_ready,
  output logic                           px_last,
  output logic                           busy,
  output logic                           frame_done
);

  localparam int IW = $clog2(PIXEL_COUNT);
  localparam int TW = timer_width(COUNTER_WIDTH);
  localparam logic [IW-1:0] LAST_IDX   = IW'(PIXEL_COUNT - 1);
  localparam logic [TW-1:0] ERASE_LOAD = TW'(ERASE_CYCLES - 1);
  localparam logic [TW-1:0] CONV_LOAD  = (TW'(1) << COUNTER_WIDTH) - TW'(1);

  state_e                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     cds_en_q, cds_en_d;
  logic [15:0]              expose_len_q, expose_len_d;
  logic [COUNTER_WIDTH-1:0] px_data_q, px_data_d;
  logic [IW-1:0]            px_index_q, px_index_d;
  logic [IW-1:0]            pixel_select_q, pixel_select_d;
  logic arr_reset_q, arr_reset_d, erase_q, erase_d, expose_q, expose_d;
  logic convert_q, convert_d, corr_q, corr_d, cds_q, cds_d, read_q, read_d;
  logic px_valid_q, px_valid_d, px_last_q, px_last_d, busy_q, busy_d;
  logic frame_done_q, frame_done_d;

  logic          timer_load;
  logic [TW-1:0] timer_load_val;
  logic          timer_done;

  phase_timer #(.WIDTH(TW)) u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_load_val),
    .done     (timer_done)
  );

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    cds_en_d       = cds_en_q;
    expose_len_d   = expose_len_q;
    px_data_d      = px_data_q;
    px_index_d     = px_index_q;
    frame_done_d   = 1'b0;
    timer_load     = 1'b0;
    timer_load_val = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d        = ST_ERASE;
          cds_en_d       = cds_en;
          expose_len_d   = expose_time;
          idx_d          = '0;
          timer_load     = 1'b1;
          timer_load_val = ERASE_LOAD;
        end
      end
      ST_ERASE: begin
        if (timer_done) begin
          state_d        = ST_EXPOSE;
          timer_load     = 1'b1;
          timer_load_val = (expose_len_q == '0) ? '0 : TW'(expose_len_q) - TW'(1);
        end
      end
      ST_EXPOSE: begin
        if (timer_done) begin
          state_d        = ST_CONVERT;
          timer_load     = 1'b1;
          timer_load_val = CONV_LOAD;
        end
      end
      ST_CONVERT: begin
        if (timer_done) begin
          state_d = ST_SETTLE;
          idx_d   = '0;
        end
      end
      ST_SETTLE: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        state_d    = ST_OUTPUT;
        px_data_d  = pixel_out;
        px_index_d = idx_q;
      end
      ST_OUTPUT: begin
        if (px_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d      = ST_IDLE;
            idx_d        = '0;
            frame_done_d = 1'b1;
          end else begin
            state_d = ST_SETTLE;
            idx_d   = idx_q + IW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes are decoded from the next state so the flops line up with the state.
    arr_reset_d    = (state_d == ST_ERASE);
    erase_d        = (state_d == ST_ERASE);
    expose_d       = (state_d == ST_EXPOSE);
    convert_d      = (state_d == ST_CONVERT);
    read_d         = (state_d == ST_SETTLE) || (state_d == ST_CAPTURE);
    corr_d         = convert_d && cds_en_d;
    cds_d          = cds_en_d && (convert_d || read_d);
    pixel_select_d = read_d ? idx_d : '0;
    px_valid_d     = (state_d == ST_OUTPUT);
    px_last_d      = px_valid_d && (idx_d == LAST_IDX);
    busy_d         = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      cds_en_q       <= 1'b0;
      expose_len_q   <= '0;
      px_data_q      <= '0;
      px_index_q     <= '0;
      pixel_select_q <= '0;
      arr_reset_q    <= 1'b0;
      erase_q        <= 1'b0;
      expose_q       <= 1'b0;
      convert_q      <= 1'b0;
      corr_q         <= 1'b0;
      cds_q          <= 1'b0;
      read_q         <= 1'b0;
      px_valid_q     <= 1'b0;
      px_last_q      <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cds_en_q       <= cds_en_d;
      expose_len_q   <= expose_len_d;
      px_data_q      <= px_data_d;
      px_index_q     <= px_index_d;
      pixel_select_q <= pixel_select_d;
      arr_reset_q    <= arr_reset_d;
      erase_q        <= erase_d;
      expose_q       <= expose_d;
      convert_q      <= convert_d;
      corr_q         <= corr_d;
      cds_q          <= cds_d;
      read_q         <= read_d;
      px_valid_q     <= px_valid_d;
      px_last_q      <= px_last_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign arr_reset    = arr_reset_q;
  assign erase        = erase_q;
  assign expose       = expose_q;
  assign convert      = convert_q;
  assign corr         = corr_q;
  assign cds          = cds_q;
  assign read         = read_q;
  assign pixel_select = pixel_select_q;
  assign px_data      = px_data_q;
  assign px_index     = px_index_q;
  assign px_valid     = px_valid_q;
  assign px_last      = px_last_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;

endmodule
`default_nettype wire
